q_meas_avg: RTL and testbench



---
 rtl/q_meas_avg.sv | 87 ++++++++
 tb/tb_q_meas_avg.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_meas_avg.sv
// Settle-then-average measurement front-end: waits SETTLE cycles after any i_ref change or
// retrigger, averages 2^LOG2_N ADC samples and pulses ready with the result.
module q_meas_avg #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned SETTLE = 16,
    parameter int unsigned LOG2_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_ref,
    input  logic             retrigger,
    input  logic             adc_valid,
    input  logic [WIDTH-1:0] adc_data,
    output logic [WIDTH-1:0] measured_q,
    output logic             ready,
    output logic             busy
);

    localparam int unsigned AccW = WIDTH + LOG2_N;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SmpW = LOG2_N + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
    localparam logic [SmpW-1:0] SmpLast = SmpW'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {StSettle, StAccum, StDone, StWait} state_e;

    state_e          state_q;
    logic [WIDTH-1:0] i_ref_q;
    logic [CntW-1:0]  settle_cnt_q;
    logic [SmpW-1:0]  smp_cnt_q;
    logic [AccW-1:0]  acc_q;
    logic             chg;
    logic [AccW-1:0]  acc_sum;

    assign chg     = (i_ref != i_ref_q) | retrigger;
    assign acc_sum = acc_q + AccW'(adc_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSettle;
            i_ref_q      <= i_ref;
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            measured_q   <= '0;
            ready        <= 1'b0;
            busy         <= 1'b1;
        end else begin
            i_ref_q <= i_ref;
            ready   <= 1'b0;
            // A change restarts the settle window from any state, including mid-accumulation.
            if (chg) begin
                state_q      <= StSettle;
                settle_cnt_q <= '0;
                busy         <= 1'b1;
            end else begin
                unique case (state_q)
                    StSettle: begin
                        if (settle_cnt_q == CntLast) begin
                            state_q   <= StAccum;
                            acc_q     <= '0;
                            smp_cnt_q <= '0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + CntW'(1);
                        end
                    end
                    StAccum: begin
                        if (adc_valid) begin
                            acc_q     <= acc_sum;
                            smp_cnt_q <= smp_cnt_q + SmpW'(1);
                            if (smp_cnt_q == SmpLast) begin
                                state_q    <= StDone;
                                measured_q <= acc_sum[AccW-1:LOG2_N];
                                ready      <= 1'b1;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    StDone:  state_q <= StWait;
                    StWait:  state_q <= StWait;
                    default: state_q <= StSettle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_q_meas_avg.sv
// Directed bench for q_meas_avg: a cycle-indexed reference model checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_q_meas_avg;

    localparam int W = 10;
    localparam int S = 4;
    localparam int L = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_ref;
    logic         retrigger;
    logic         adc_valid;
    logic [W-1:0] adc_data;
    logic [W-1:0] measured_q;
    logic         ready;
    logic         busy;

    q_meas_avg #(.WIDTH(W), .SETTLE(S), .LOG2_N(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ref      (i_ref),
        .retrigger  (retrigger),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .measured_q (measured_q),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a measurement opens at the change cycle t, samples count only from
    // cycle t+S+1 on, and the N-th accepted sample yields sum/N and ready in the next cycle.
    bit           model_on = 1'b0;
    bit           m_pending;
    int           m_elig;
    int           m_sum;
    int           m_nsamp;
    logic [W-1:0] m_prev;
    int           e_q;
    bit           e_ready;
    bit           e_busy;

    always @(posedge clk) begin
        int cur;
        cur = cyc;
        if (rst) begin
            model_on  = 1'b1;
            m_pending = 1'b1;
            m_elig    = cur + S + 1;
            m_sum     = 0;
            m_nsamp   = 0;
            e_q       = 0;
            e_ready   = 1'b0;
        end else begin
            e_ready = 1'b0;
            if ((i_ref != m_prev) || retrigger) begin
                m_pending = 1'b1;
                m_elig    = cur + S + 1;
                m_sum     = 0;
                m_nsamp   = 0;
            end else if (m_pending && cur >= m_elig && adc_valid) begin
                m_sum   = m_sum + int'(adc_data);
                m_nsamp = m_nsamp + 1;
                if (m_nsamp == N) begin
                    e_q       = m_sum / N;
                    e_ready   = 1'b1;
                    m_pending = 1'b0;
                end
            end
        end
        e_busy = m_pending;
        m_prev = i_ref;
        cyc    = cur + 1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("measured_q", int'(measured_q), e_q);
            check("ready", int'(ready), int'(e_ready));
            check("busy", int'(busy), int'(e_busy));
            if (ready === 1'b1) ready_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        adc_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [W-1:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic start_chg(input logic [W-1:0] iref, input logic rt);
        i_ref     = iref;
        retrigger = rt;
        adc_valid = 1'b0;
        tick();
        retrigger = 1'b0;
    endtask

    task automatic wait_ready(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (ready === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("ready_timeout", 0, 1);
    endtask

    initial begin
        int c0;
        int r0;
        int at;
        rst       = 1'b1;
        i_ref     = '0;
        retrigger = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 10'd77;
        tick();
        tick();
        check("rst_measured_q", int'(measured_q), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_busy", int'(busy), 1);

        // First measurement after reset needs a full settle: ready at S+N+1 after last rst cycle.
        c0  = cyc - 1;
        rst = 1'b0;
        wait_ready(30, at);
        check("rst_to_ready_cycles", at - c0, 9);
        check("rst_first_value", int'(measured_q), 77);
        adc_valid = 1'b0;
        tick();

        // Basic average; 999 is presented during the change and settle cycles.
        c0        = cyc;
        i_ref     = 10'd500;
        adc_valid = 1'b1;
        adc_data  = 10'd999;
        repeat (5) tick();
        for (int k = 0; k < 4; k++) begin
            adc_data = W'(100 + 2 * k);
            tick();
        end
        adc_valid = 1'b0;
        check("basic_ready", int'(ready), 1);
        check("basic_value", int'(measured_q), 103);
        check("basic_latency", cyc - c0, 9);
        tick();
        check("basic_ready_one_cycle", int'(ready), 0);

        // Truncation with adc_valid gaps: 1+1+1+2 = 5, /4 -> 1.
        c0 = cyc;
        start_chg(10'd501, 1'b0);
        idle(4);
        for (int k = 0; k < 7; k++) begin
            adc_valid = (k % 2 == 0);
            adc_data  = (k == 6) ? W'(2) : W'(1);
            tick();
        end
        adc_valid = 1'b0;
        check("trunc_ready", int'(ready), 1);
        check("trunc_value", int'(measured_q), 1);
        check("trunc_latency", cyc - c0, 12);
        tick();

        start_chg(10'd502, 1'b0);
        idle(4);
        repeat (4) send(10'd1023);
        check("fullscale_ready", int'(ready), 1);
        check("fullscale_value", int'(measured_q), 1023);
        tick();

        // Abort after two samples, then a clean measurement of 200s.
        r0 = ready_cnt;
        start_chg(10'd503, 1'b0);
        idle(4);
        send(10'd50);
        send(10'd60);
        start_chg(10'd504, 1'b0);
        idle(4);
        repeat (4) send(10'd200);
        check("abort_ready", int'(ready), 1);
        check("abort_value", int'(measured_q), 200);
        idle(2);
        check("abort_ready_count", ready_cnt - r0, 1);

        // Change coincident with the fourth sample: abort wins.
        start_chg(10'd505, 1'b0);
        idle(4);
        repeat (3) send(10'd10);
        i_ref     = 10'd506;
        adc_valid = 1'b1;
        adc_data  = 10'd10;
        tick();
        adc_valid = 1'b0;
        check("coincident_no_ready", int'(ready), 0);
        check("coincident_value_held", int'(measured_q), 200);
        idle(4);
        repeat (4) send(10'd40);
        check("coincident_recover_value", int'(measured_q), 40);
        idle(1);

        // Retrigger in WAIT with i_ref constant: 7+8+9+10 = 34, /4 -> 8.
        c0 = cyc;
        start_chg(10'd506, 1'b1);
        idle(4);
        send(10'd7);
        send(10'd8);
        send(10'd9);
        send(10'd10);
        check("retrig_ready", int'(ready), 1);
        check("retrig_value", int'(measured_q), 8);
        check("retrig_latency", cyc - c0, 9);
        idle(1);

        // Reset mid-ACCUM.
        start_chg(10'd507, 1'b0);
        idle(4);
        send(10'd300);
        send(10'd300);
        rst = 1'b1;
        tick();
        tick();
        check("midrst_measured_q", int'(measured_q), 0);
        check("midrst_ready", int'(ready), 0);
        check("midrst_busy", int'(busy), 1);
        c0        = cyc - 1;
        rst       = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 10'd33;
        wait_ready(30, at);
        check("midrst_to_ready_cycles", at - c0, 9);
        check("midrst_value", int'(measured_q), 33);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
